// File: rtl/output_display_unit_if.sv
// Load/data bus from the control, input and arithmetic units, plus the display
// outputs of the output display unit.
interface output_display_unit_if;
    logic        LOAD_N;
    logic        SRC_SEL;
    logic [7:0]  IN_DATA;
    logic [7:0]  AU_DATA;
    logic [6:0]  SEG;
    logic [3:0]  AN;
    logic        BUSY;
    logic [11:0] BCD;

    modport master (output LOAD_N, SRC_SEL, IN_DATA, AU_DATA,
                    input  SEG, AN, BUSY, BCD);
    modport slave  (input  LOAD_N, SRC_SEL, IN_DATA, AU_DATA,
                    output SEG, AN, BUSY, BCD);
endinterface

// File: rtl/output_display_unit.sv
// Calculator output stage: captures a value, converts it to BCD by sequential double-dabble
// and drives a 4-digit multiplexed 7-segment display. Define SIGNED_DISPLAY_EN for two's complement.
module output_display_unit #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                   CLK,
    input  logic                   CLR,
    output_display_unit_if.slave   bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, state_nxt;
    logic [7:0]    cap;
    logic          prev_load_n;
    logic [19:0]   shreg;
    logic [19:0]   shreg_adj;
    logic [3:0]    bit_cnt;
    logic          neg_pend;
    logic          neg;
    logic [11:0]   bcd;
    logic [CW-1:0] ref_cnt;
    logic [1:0]    digit;
    logic [7:0]    mux_val;
    logic [7:0]    mag;
    logic          sign;
    logic          start;
    logic [6:0]    glyph;

    assign mux_val = bus.SRC_SEL ? bus.AU_DATA : bus.IN_DATA;
    // A held-low strobe only restarts when the selected value actually changes.
    assign start   = !bus.LOAD_N && (prev_load_n || (mux_val != cap));

`ifdef SIGNED_DISPLAY_EN
    assign sign = mux_val[7];
    assign mag  = mux_val[7] ? 8'(-mux_val) : mux_val;
`else
    assign sign = 1'b0;
    assign mag  = mux_val;
`endif

    always_comb begin
        shreg_adj = shreg;
        for (int i = 0; i < 3; i++) begin
            if (shreg[8+4*i +: 4] >= 4'd5)
                shreg_adj[8+4*i +: 4] = shreg[8+4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = SHIFT;
        end else begin
            case (state)
                SHIFT:   if (bit_cnt == 4'd7) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            cap         <= '0;
            prev_load_n <= 1'b1;
            shreg       <= '0;
            bit_cnt     <= '0;
            neg_pend    <= 1'b0;
            neg         <= 1'b0;
            bcd         <= '0;
        end else begin
            prev_load_n <= bus.LOAD_N;
            if (!bus.LOAD_N)
                cap <= mux_val;
            if (start) begin
                shreg    <= {12'd0, mag};
                bit_cnt  <= '0;
                neg_pend <= sign;
            end else if (state == SHIFT) begin
                shreg   <= shreg_adj << 1;
                bit_cnt <= bit_cnt + 4'd1;
            end else if (state == DONE) begin
                bcd <= shreg[19:8];
                neg <= neg_pend;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            ref_cnt <= '0;
            digit   <= '0;
        end else if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            digit   <= digit + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + CW'(1);
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    // Leading-zero blanking: tens is shown whenever hundreds is non-zero.
    always_comb begin
        glyph = BLANK;
        case (digit)
            2'd0:    glyph = seg_of(bcd[3:0]);
            2'd1:    if (bcd[11:4] != 8'd0) glyph = seg_of(bcd[7:4]);
            2'd2:    if (bcd[11:8] != 4'd0) glyph = seg_of(bcd[11:8]);
            default: if (neg) glyph = MINUS;
        endcase
    end

    assign bus.SEG  = SEG_ACTIVE_LOW ? glyph : ~glyph;
    assign bus.AN   = ~(4'b0001 << digit);
    assign bus.BUSY = (state != IDLE);
    assign bus.BCD  = bcd;
endmodule
